// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external 64-bit ALU between two requesters
//   with a single registered result buffer
// Ports: clk, rst_n (async active-low); req0/req1 valid/ready/op/a/b request ports;
//   alu_rs1/alu_rs2/alu_control out to the ALU, alu_rd/alu_carry/alu_overflow back;
//   resp_valid/resp_ready handshake with resp_id/result/zero/carry/overflow/err.
// Optional: define ALU_ARB_PERF_EN to add perf_grant0/perf_grant1/perf_stall counters.
module alu_arbiter #(
   parameter int XLEN   = 64,
   parameter int OP_W   = 4,
   parameter int MAX_OP = 9
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_op,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_op,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic [XLEN-1:0] alu_rs1,
   output logic [XLEN-1:0] alu_rs2,
   output logic [OP_W-1:0] alu_control,
   input  logic [XLEN-1:0] alu_rd,
   input  logic            alu_carry,
   input  logic            alu_overflow,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_id,
   output logic [XLEN-1:0] resp_result,
   output logic            resp_zero,
   output logic            resp_carry,
   output logic            resp_overflow,
   output logic            resp_err
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [31:0]     perf_grant0,
   output logic [31:0]     perf_grant1,
   output logic [31:0]     perf_stall
`endif
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state, state_nx;
   logic last_grant, can_issue, g0, g1, hs, err, arith;
   always_comb begin
      // rst_n gates issue so no port sees ready while reset is held
      can_issue   = rst_n & (state == EMPTY | resp_ready);
      g0          = can_issue & req0_valid & (!req1_valid | last_grant);
      g1          = can_issue & req1_valid & (!req0_valid | !last_grant);
      hs          = g0 | g1;
      req0_ready  = g0;
      req1_ready  = g1;
      alu_rs1     = g0 ? req0_a : g1 ? req1_a : '0;
      alu_rs2     = g0 ? req0_b : g1 ? req1_b : '0;
      alu_control = g0 ? req0_op : g1 ? req1_op : '0;
      err         = alu_control > OP_W'(MAX_OP);
      // the ALU only refreshes its flags for ADD and SUB
      arith       = alu_control == OP_W'(2) | alu_control == OP_W'(6);
      state_nx    = (hs | (state == FULL & !resp_ready)) ? FULL : EMPTY;
   end
   assign resp_valid = state == FULL;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= EMPTY;
         last_grant    <= 1'b1;
         resp_id       <= 1'b0;
         resp_result   <= '0;
         resp_zero     <= 1'b0;
         resp_carry    <= 1'b0;
         resp_overflow <= 1'b0;
         resp_err      <= 1'b0;
      end else begin
         state <= state_nx;
         if (hs) begin
            last_grant    <= g1;
            resp_id       <= g1;
            resp_result   <= err ? '0 : alu_rd;
            resp_zero     <= err | (alu_rd == '0);
            resp_carry    <= arith & alu_carry;
            resp_overflow <= arith & alu_overflow;
            resp_err      <= err;
         end
      end
   end
`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_grant0 <= '0;
         perf_grant1 <= '0;
         perf_stall  <= '0;
      end else begin
         if (g0 && perf_grant0 != '1) perf_grant0 <= perf_grant0 + 32'd1;
         if (g1 && perf_grant1 != '1) perf_grant1 <= perf_grant1 + 32'd1;
         if (resp_valid && !resp_ready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a behavioural ALU stub
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, alu_control;
  logic [63:0] req0_a, req0_b, req1_a, req1_b, alu_rs1, alu_rs2, alu_rd, resp_result;
  logic alu_carry, alu_overflow, resp_valid, resp_ready, resp_id;
  logic resp_zero, resp_carry, resp_overflow, resp_err;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif
  int tests = 0, fails = 0;
  typedef struct {logic id; logic [63:0] res; logic z, c, o, e;} exp_t;
  exp_t q[$];
  logic lg = 1'b1, can_m, e0, e1;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_control(alu_control),
    .alu_rd(alu_rd), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_carry(resp_carry), .resp_overflow(resp_overflow), .resp_err(resp_err)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [65:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = a - b;
    case (op)
      4'h0: alu_f = {2'b11, a & b};
      4'h1: alu_f = {2'b11, a | b};
      4'h2: alu_f = {s[64], (a[63] == b[63]) && (s[63] != a[63]), s[63:0]};
      4'h3: alu_f = {2'b11, a ^ b};
      4'h4: alu_f = {2'b11, a << b[5:0]};
      4'h5: alu_f = {2'b11, a >> b[5:0]};
      4'h6: alu_f = {a < b, (a[63] != b[63]) && (d[63] != a[63]), d};
      4'h7: alu_f = {2'b11, $signed(a) >>> b[5:0]};
      4'h8: alu_f = {2'b11, 63'd0, $signed(a) < $signed(b)};
      4'h9: alu_f = {2'b11, 63'd0, a < b};
      default: alu_f = {2'b11, 64'hBAD};
    endcase
  endfunction
  always_comb {alu_carry, alu_overflow, alu_rd} = alu_f(alu_control, alu_rs1, alu_rs2);
  function automatic exp_t mk(input logic id, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [65:0] r;
    r = alu_f(op, a, b);
    mk.id = id;
    mk.e = op > 4'h9;
    mk.res = mk.e ? 64'd0 : r[63:0];
    mk.z = mk.res == 64'd0;
    mk.c = !mk.e && (op == 4'h2 || op == 4'h6) && r[65];
    mk.o = !mk.e && (op == 4'h2 || op == 4'h6) && r[64];
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      lg = 1'b1;
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      chk("rst_valid", resp_valid, 1'b0);
    end else begin
      can_m = q.size() == 0 || resp_ready;
      e0 = can_m && req0_valid && (!req1_valid || lg);
      e1 = can_m && req1_valid && (!req0_valid || !lg);
      chk("resp_valid", resp_valid, q.size() != 0);
      if (resp_valid && q.size() != 0) begin
        chk("sb_id", resp_id, q[0].id);
        chk("sb_result", resp_result, q[0].res);
        chk("sb_zero", resp_zero, q[0].z);
        chk("sb_carry", resp_carry, q[0].c);
        chk("sb_overflow", resp_overflow, q[0].o);
        chk("sb_err", resp_err, q[0].e);
        if (resp_ready) void'(q.pop_front());
      end
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      if (e0) begin q.push_back(mk(1'b0, req0_op, req0_a, req0_b)); lg = 1'b0; end
      if (e1) begin q.push_back(mk(1'b1, req1_op, req1_a, req1_b)); lg = 1'b1; end
    end
  end
  task automatic drv(input logic v0, input logic [3:0] o0, input logic [63:0] a0, input logic [63:0] b0,
                     input logic v1, input logic [3:0] o1, input logic [63:0] a1, input logic [63:0] b1,
                     input logic rr);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    resp_ready = rr;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [63:0] save;
    logic sid;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc;
    chk("rst_result", resp_result, 64'd0);
    chk("rst_id", resp_id, 1'b0);
    chk("rst_flags", {resp_zero, resp_carry, resp_overflow, resp_err}, 4'b0000);
    cyc;
    rst_n = 1'b1;
    drv(1, 4'h2, 64'd5, 64'd7, 0, 0, 0, 0, 1);
    #1 chk("t1_ready", req0_ready, 1'b1);
    cyc;
    chk("t1_valid", resp_valid, 1'b1);
    chk("t1_id", resp_id, 1'b0);
    chk("t1_result", resp_result, 64'd12);
    chk("t1_zero", resp_zero, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sid = resp_id;
      drv(1, 4'(i % 10), {$urandom, $urandom}, {$urandom, $urandom},
          1, 4'((i + 3) % 10), {$urandom, $urandom}, 64'(i), 1);
      cyc;
      if (i > 0) chk("t2_alt", resp_id, !sid);
    end
    drv(1, 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 1);
    cyc;
    chk("t3_ovf", resp_overflow, 1'b1);
    chk("t3_carry", resp_carry, 1'b0);
    chk("t3_sum", resp_result, 64'h8000_0000_0000_0000);
    drv(1, 4'h0, 64'hF0, 64'h0F, 0, 0, 0, 0, 1);
    cyc;
    chk("t3_and", resp_result, 64'd0);
    chk("t3_zero", resp_zero, 1'b1);
    chk("t3_and_flags", {resp_carry, resp_overflow}, 2'b00);
    drv(1, 4'h3, 64'h1234, 64'h00FF, 1, 4'h1, 64'h5000, 64'h0007, 1);
    cyc;
    save = resp_result;
    sid = resp_id;
    drv(1, 4'h6, 64'd9, 64'd4, 1, 4'h2, 64'd100, 64'd1, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_ready0", req0_ready, 1'b0);
      chk("t4_ready1", req1_ready, 1'b0);
      cyc;
      chk("t4_hold", resp_result, save);
      chk("t4_hold_v", resp_valid, 1'b1);
    end
    resp_ready = 1'b1;
    #1 chk("t4_pass_ready", sid ? req0_ready : req1_ready, 1'b1);
    cyc;
    chk("t4_pass_id", resp_id, !sid);
    drv(0, 0, 0, 0, 1, 4'hC, 64'd5, 64'd6, 1);
    cyc;
    chk("t5_err", resp_err, 1'b1);
    chk("t5_result", resp_result, 64'd0);
    chk("t5_zero", resp_zero, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_valid", resp_valid, 1'b0);
    @(negedge clk);
    cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(1, 4'(i % 10), 64'(i * 3), 64'(i), 1, 4'h2, 64'(i), 64'd1, 1);
      if (i == 0) begin
        #1 chk("t5_fav0", {req0_ready, req1_ready}, 2'b10);
      end
      cyc;
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc;
`ifdef ALU_ARB_PERF_EN
    chk("t6_grant0", perf_grant0, 32'd5);
    chk("t6_grant1", perf_grant1, 32'd5);
    chk("t6_stall", perf_stall, 32'd4);
`endif
    resp_ready = 1'b1;
    cyc;
    cyc;
    chk("drain_q", q.size(), 0);
    chk("drain_valid", resp_valid, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
